// File: rtl/line_window_buffer_if.sv
// Pixel stream / window bus between the raster source, line_window_buffer and the multiplier.
// frame_done exists only when LWB_FRAME_DONE_EN is defined.
interface line_window_buffer_if #(
  parameter int BITS        = 9,
  parameter int KERNEL_SIZE = 3
);
  logic                                  write_en;
  logic [BITS-1:0]                       pixel_in;
  logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] window_out;
  logic                                  out_en;
`ifdef LWB_FRAME_DONE_EN
  logic                                  frame_done;

  modport master (output write_en, pixel_in, input window_out, out_en, frame_done);
  modport slave  (input write_en, pixel_in, output window_out, out_en, frame_done);
`else
  modport master (output write_en, pixel_in, input window_out, out_en);
  modport slave  (input write_en, pixel_in, output window_out, out_en);
`endif
endinterface

// File: rtl/line_window_buffer.sv
// Raster-order KxK window generator using K-1 chained line buffers; no edge padding.
// Optional frame_done pulse is enabled by defining LWB_FRAME_DONE_EN.
module line_window_buffer #(
  parameter int BITS        = 9,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32
) (
  input logic                 clk,
  input logic                 reset,
  line_window_buffer_if.slave bus
);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int WIN_W = KERNEL_SIZE * KERNEL_SIZE * BITS;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(KERNEL_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_FILL  = ROW_W'(KERNEL_SIZE - 2);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [0:0]       state;
  logic [WIN_W-1:0] win;
  logic [WIN_W-1:0] win_shift;
  logic             out_en_q;

  logic [BITS-1:0] line_mem [0:KERNEL_SIZE-2][0:IMG_WIDTH-1];
  logic [BITS-1:0] lb_out   [0:KERNEL_SIZE-2];
  logic [BITS-1:0] new_col  [0:KERNEL_SIZE-1];

  logic col_last;
  logic frame_last;
  logic emit;

  assign col_last   = (col == COL_LAST);
  assign frame_last = col_last && (row == ROW_LAST);
  assign emit       = bus.write_en && (state == RUN) && (col >= COL_FIRST);

  // Line buffer k holds the row k+1 lines above the incoming pixel; index 0 is the newest.
  always_comb begin
    for (int k = 0; k < KERNEL_SIZE - 1; k++) lb_out[k] = line_mem[k][col];
    new_col[0] = bus.pixel_in;
    for (int k = 1; k < KERNEL_SIZE; k++) new_col[k] = lb_out[k-1];
  end

  always_comb begin
    win_shift = '0;
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      win_shift[(r*KERNEL_SIZE)*BITS +: BITS] = new_col[r];
      for (int c = 1; c < KERNEL_SIZE; c++)
        win_shift[(r*KERNEL_SIZE+c)*BITS +: BITS] = win[(r*KERNEL_SIZE+c-1)*BITS +: BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (bus.write_en) begin
      line_mem[0][col] <= bus.pixel_in;
      for (int k = 1; k < KERNEL_SIZE - 1; k++) line_mem[k][col] <= lb_out[k-1];
    end
  end

  // RUN starts with the first row that completes a window and ends after the frame's last pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col      <= '0;
      row      <= '0;
      state    <= FILL;
      win      <= '0;
      out_en_q <= 1'b0;
    end else begin
      out_en_q <= emit;
      if (bus.write_en) begin
        win <= win_shift;
        if (col_last) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (frame_last)
          state <= FILL;
        else if (col_last && (row == ROW_FILL))
          state <= RUN;
      end
    end
  end

  assign bus.window_out = win;
  assign bus.out_en     = out_en_q;

`ifdef LWB_FRAME_DONE_EN
  logic frame_done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) frame_done_q <= 1'b0;
    else        frame_done_q <= emit && frame_last;
  end

  assign bus.frame_done = frame_done_q;
`endif
endmodule

// File: tb/tb_line_window_buffer.sv
// Bench for line_window_buffer: 2-D image model of the frame, per-cycle compare, directed frames.
module tb_line_window_buffer;
  localparam int BITS = 9;
  localparam int K    = 3;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int WW   = K * K * BITS;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  line_window_buffer_if #(.BITS(BITS), .KERNEL_SIZE(K)) bus ();

  line_window_buffer #(
    .BITS(BITS), .KERNEL_SIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  int              img [H][W];
  int              m_row;
  int              m_col;
  logic            exp_out_en;
  logic            exp_fd;
  logic [WW-1:0]   exp_window;
  logic [WW-1:0]   win_q [$];
  logic [WW-1:0]   ref_q [$];
  int              fd_count;
  int              fd_slot0;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_window(input string name, input logic [WW-1:0] actual, input logic [WW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic int slot_of(input logic [WW-1:0] w, input int s);
    return int'(w[s*BITS +: BITS]);
  endfunction

  task automatic model_reset();
    m_row      = 0;
    m_col      = 0;
    exp_out_en = 1'b0;
    exp_fd     = 1'b0;
    exp_window = '0;
  endtask

  // A window exists once KxK pixels above-left of the current one have been seen this frame.
  task automatic model_accept(input int pix);
    img[m_row][m_col] = pix;
    exp_out_en = (m_row >= K - 1) && (m_col >= K - 1);
    exp_fd     = exp_out_en && (m_row == H - 1) && (m_col == W - 1);
    if (exp_out_en)
      for (int rr = 0; rr < K; rr++)
        for (int cc = 0; cc < K; cc++)
          exp_window[(rr*K+cc)*BITS +: BITS] = BITS'(img[m_row-rr][m_col-cc]);
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      m_row = (m_row == H - 1) ? 0 : m_row + 1;
    end
  endtask

  task automatic apply_stimulus(input logic we, input int pix);
    @(negedge clk);
    bus.write_en = we;
    bus.pixel_in = BITS'(pix);
    @(posedge clk);
    if (we) model_accept(pix);
    else begin
      exp_out_en = 1'b0;
      exp_fd     = 1'b0;
    end
  endtask

  task automatic hold_reset(input int cycles);
    @(negedge clk);
    bus.write_en = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    repeat (cycles) @(negedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic send_frame(input int offset, input int gap);
    for (int p = 0; p < W * H; p++) begin
      apply_stimulus(1'b1, p + 1 + offset);
      for (int g = 0; g < gap; g++) apply_stimulus(1'b0, 0);
    end
  endtask

  task automatic flush();
    apply_stimulus(1'b0, 0);
    apply_stimulus(1'b0, 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check_output("reset_out_en", int'(bus.out_en), 0);
      check_window("reset_window", bus.window_out, '0);
`ifdef LWB_FRAME_DONE_EN
      check_output("reset_frame_done", int'(bus.frame_done), 0);
`endif
    end else begin
      check_output("out_en", int'(bus.out_en), int'(exp_out_en));
      if (exp_out_en) check_window("window", bus.window_out, exp_window);
      if (bus.out_en === 1'b1) win_q.push_back(bus.window_out);
`ifdef LWB_FRAME_DONE_EN
      check_output("frame_done", int'(bus.frame_done), int'(exp_fd));
      if (bus.frame_done === 1'b1) begin
        fd_count++;
        fd_slot0 = slot_of(bus.window_out, 0);
      end
`endif
    end
  end

  initial begin
    int first_exp [9] = '{11, 10, 9, 7, 6, 5, 3, 2, 1};

    bus.write_en = 1'b0;
    bus.pixel_in = '0;
    fd_count     = 0;
    fd_slot0     = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    $display("[TB] continuous frame");
    win_q.delete();
    fd_count = 0;
    send_frame(0, 0);
    flush();
    check_output("s1_count", win_q.size(), 4);
    for (int s = 0; s < 9; s++) check_output("s1_first_slot", slot_of(win_q[0], s), first_exp[s]);
    check_output("s1_w1_slot0", slot_of(win_q[1], 0), 12);
    check_output("s1_w2_slot0", slot_of(win_q[2], 0), 15);
    check_output("s1_w3_slot0", slot_of(win_q[3], 0), 16);
    check_output("s1_w3_topleft", slot_of(win_q[3], 8), 6);
`ifdef LWB_FRAME_DONE_EN
    check_output("s1_fd_count", fd_count, 1);
    check_output("s1_fd_slot0", fd_slot0, 16);
`endif
    ref_q = win_q;

    $display("[TB] frame with idle gaps");
    win_q.delete();
    send_frame(0, 3);
    flush();
    check_output("s2_count", win_q.size(), 4);
    for (int i = 0; i < 4; i++) check_window("s2_same_window", win_q[i], ref_q[i]);

    $display("[TB] mid-frame reset");
    for (int p = 0; p < 7; p++) apply_stimulus(1'b1, p + 1);
    hold_reset(3);
    win_q.delete();
    send_frame(0, 0);
    flush();
    check_output("s3_count", win_q.size(), 4);
    check_window("s3_first_window", win_q[0], ref_q[0]);

    $display("[TB] two frames back-to-back");
    win_q.delete();
    fd_count = 0;
    send_frame(0, 0);
    send_frame(100, 0);
    flush();
    check_output("s4_count", win_q.size(), 8);
    check_output("s4_f1_last_slot0", slot_of(win_q[3], 0), 16);
    check_output("s4_f2_first_topleft", slot_of(win_q[4], 8), 101);
    check_output("s4_f2_first_slot0", slot_of(win_q[4], 0), 111);
    check_output("s4_f2_last_slot0", slot_of(win_q[7], 0), 116);
`ifdef LWB_FRAME_DONE_EN
    check_output("s4_fd_count", fd_count, 2);
`endif

    $display("[TB] signed data");
    win_q.delete();
    for (int p = 0; p < W * H; p++) apply_stimulus(1'b1, -256);
    flush();
    check_output("s5_count", win_q.size(), 4);
    foreach (win_q[i])
      for (int s = 0; s < K * K; s++) check_output("s5_slot", slot_of(win_q[i], s), 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
